vec_store_arbiter: RTL
======================

# vec_store_arbiter

Shares a single word-wide memory write port between `NREQ` vector requesters. Each requester offers a 16-lane × 16-bit vector and a base address. The block grants one requester at a time, latches its vector, and issues 16 consecutive word writes with a ready/valid backpressure handshake. It then signals completion back to the granted requester. It sits between the vector execution units and the data-memory write port, and is the single sequencer for vector stores into memory.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters, legal range 2..4.
- `AW`, default 16: memory word-address width.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req` in `[NREQ-1:0]`: per-requester store request level.
- `req_addr` in `[NREQ-1:0][AW-1:0]`: per-requester base word address.
- `req_data` in `[NREQ-1:0][15:0][15:0]`: per-requester vector; lane 0 is `[0]`.
- `grant` out `[NREQ-1:0]`: one-hot, one-cycle pulse when a request is accepted.
- `done` out `[NREQ-1:0]`: one-hot, one-cycle pulse after the last lane is written.
- `busy` out 1: high in any state other than IDLE.
- `mem_we` out 1: write valid.
- `mem_addr` out `AW`: write word address.
- `mem_wdata` out 16: write data.
- `mem_ready` in 1: memory accepts the current word when `mem_we && mem_ready` at a rising edge.

## Operation
- States: IDLE, BURST, DONE.
- **IDLE:**
  - If `req` is nonzero at the edge, select a winner (see Configuration).
  - Latch `req_data[w]` into a 16×16 buffer and `req_addr[w]` into the base register.
  - Record `w`, clear the lane counter, go to BURST.
  - `grant[w]` is high for exactly the first BURST cycle.
- **BURST:**
  - `mem_we`=1, `mem_addr` = base + lane (modulo 2^AW, wraps silently), `mem_wdata` = buffer[lane].
  - On an accepted word the lane counter increments.
  - On acceptance of lane 15, go to DONE.
  - Without `mem_ready`, all outputs hold stable.
- **DONE:** `done[w]`=1 for one cycle, then IDLE.
- Input sampling:
  - `req`, `req_addr` and `req_data` are sampled only in IDLE and ignored elsewhere.
  - A requester keeps `req` high until it sees `grant`.
  - Later changes to its data do not affect the burst in flight.
- A requester still holding `req` when the block returns to IDLE is treated as a new request.
- The lane counter is 5 bits or uses an explicit last-lane flag; it must not alias lane 15 to an end condition early.
- Reset values: state IDLE, `grant`=0, `done`=0, `busy`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, lane=0, round-robin pointer=0. The buffer contents are don't-care.
- Reset mid-burst: the burst is aborted immediately and `mem_we` drops asynchronously with `rst`. No `done` is issued and the aborted requester must re-request.

## Timing
- Request seen at edge E0 → `grant` and first `mem_we` (lane 0) in cycle C1 following E0.
- With `mem_ready` held high:
  - Lanes 0..15 occupy C1..C16.
  - `done` occurs in C17.
  - IDLE occurs in C18, and a new request can be accepted at the edge ending C18.
  - Vector-to-vector throughput is 18 cycles.
- Each cycle with `mem_ready`=0 during BURST adds one cycle; `mem_addr` and `mem_wdata` are unchanged across stalls.
- `busy` is high from C1 through C17 inclusive.
- All outputs are driven from registers or from state decode only, with no combinational path from `req` or `mem_ready` to the outputs.

## Configuration
- Macro `VSA_ROUND_ROBIN_EN`.
- **Defined:** round-robin arbitration.
  - The search starts at the pointer and takes the first asserted `req` upward, wrapping.
  - On grant, the pointer becomes (w+1) mod `NREQ`.
- **Undefined:** fixed priority.
  - The lowest asserted index wins.
  - No pointer register exists.

## Test plan
- Single request: `req`=01, `req_addr[0]`=0x0100, lanes = 0xA000+i, `mem_ready`=1. Expected: `grant`=01 in C1; writes 0x0100..0x010F with data 0xA000..0xA00F in C1..C16; `done`=01 in C17.
- Backpressure: as above, with `mem_ready` low for 3 cycles during lane 5. Expected: lane 5 held at address 0x0105 with stable data; `done` arrives in C20.
- Contention, both `req` held continuously:
  - With `VSA_ROUND_ROBIN_EN`: grants alternate 01, 10, 01.
  - Without the macro: every grant is 01.
- Address wrap: base 0xFFF8 with AW=16. Expected: addresses 0xFFF8..0xFFFF then 0x0000..0x0007.
- Reset mid-burst: assert `rst` during lane 7. Expected: `mem_we`=0 immediately; no `done`; after release, `busy`=0 and a fresh request restarts from lane 0.
- Data isolation: change `req_data[0]` after `grant`. Expected: the burst still writes the values latched at grant.

Source files
------------

// File: rtl/vec_store_arbiter_if.sv
// Bundle between the vector requesters, the store arbiter and the memory write port.
// Memory handshake: a word moves when mem_we (valid) and mem_ready are both high at a rising edge; while mem_we is high and mem_ready is low, mem_addr and mem_wdata hold.
interface vec_store_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 16
);
    logic [NREQ-1:0]                  req;
    logic [NREQ-1:0][AW-1:0]          req_addr;
    logic [NREQ-1:0][15:0][15:0]      req_data;
    logic [NREQ-1:0]                  grant;
    logic [NREQ-1:0]                  done;
    logic                             busy;
    logic                             mem_we;
    logic [AW-1:0]                    mem_addr;
    logic [15:0]                      mem_wdata;
    logic                             mem_ready;
    logic [1:0]                       state_dbg;

    modport master (
        input  req, req_addr, req_data, mem_ready,
        output grant, done, busy, mem_we, mem_addr, mem_wdata, state_dbg
    );

    modport slave (
        output req, req_addr, req_data, mem_ready,
        input  grant, done, busy, mem_we, mem_addr, mem_wdata, state_dbg
    );
endinterface

// File: rtl/vec_store_arbiter.sv
// Grants one vector requester at a time and streams its 16 lanes to a word-wide memory port.
// Define VSA_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest requester index wins.
module vec_store_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    vec_store_arbiter_if.master   bus
);
    localparam int IW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [4:0]      lane;
    logic [4:0]      next_lane;
    logic [IW-1:0]   win;
    logic [IW-1:0]   cur;
    logic [AW-1:0]   base;
    logic [15:0]     vbuf [16];
    logic            start;

    assign start         = (state == IDLE) && (|bus.req);
    assign next_lane     = lane + 5'd1;
    assign bus.state_dbg = state;

`ifdef VSA_ROUND_ROBIN_EN
    logic [IW-1:0] rr_ptr;
    logic          found;

    // Search upward from the pointer, wrapping, and take the first asserted request.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && bus.req[(int'(rr_ptr) + i) % NREQ]) begin
                win   = IW'((int'(rr_ptr) + i) % NREQ);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (start) begin
            rr_ptr <= (int'(win) == NREQ - 1) ? '0 : win + IW'(1);
        end
    end
`else
    always_comb begin
        win = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[i]) win = IW'(i);
        end
    end
`endif

    // Vector snapshot; contents only matter once a burst has started.
    always_ff @(posedge clk) begin
        if (start) begin
            for (int i = 0; i < 16; i++) vbuf[i] <= bus.req_data[win][i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            lane          <= '0;
            cur           <= '0;
            base          <= '0;
            bus.grant     <= '0;
            bus.done      <= '0;
            bus.busy      <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.grant <= '0;
            bus.done  <= '0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        state         <= BURST;
                        cur           <= win;
                        base          <= bus.req_addr[win];
                        lane          <= '0;
                        bus.grant     <= NREQ'(1) << win;
                        bus.busy      <= 1'b1;
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= bus.req_addr[win];
                        bus.mem_wdata <= bus.req_data[win][0];
                    end
                end
                BURST: begin
                    if (bus.mem_ready) begin
                        // Five-bit lane keeps lane 15 distinct from the end condition.
                        if (lane == 5'd15) begin
                            state      <= DONE;
                            bus.mem_we <= 1'b0;
                            bus.done   <= NREQ'(1) << cur;
                        end else begin
                            lane          <= next_lane;
                            bus.mem_addr  <= base + AW'(next_lane);
                            bus.mem_wdata <= vbuf[next_lane[3:0]];
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
